// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl: waits for a synchronised trigger, samples sample_in at a divided rate,
// packs PACK samples per word and pushes each word into the sampler FIFO.
module sample_capture_ctrl #(
   parameter int SAMPLE_WIDTH = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int DIV_WIDTH    = 16,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    enable,
   input  logic [DIV_WIDTH-1:0]    clk_div,
   input  logic [CNT_WIDTH-1:0]    word_limit,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    trig_in,
   input  logic                    fifo_full,
   output logic                    fifo_wr_en,
   output logic [DATA_WIDTH-1:0]   fifo_wr_data,
   output logic                    busy,
   output logic                    done_pulse,
   output logic                    overflow,
   output logic [CNT_WIDTH-1:0]    words_done
);
   localparam int PACK = DATA_WIDTH / SAMPLE_WIDTH;
   localparam int IW   = (PACK > 1) ? $clog2(PACK) : 1;

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  div_l_q, div_l_d, div_q, div_d;
   logic [CNT_WIDTH-1:0]  lim_q, lim_d, words_q, words_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d, pword_q, pword_d, hold_q, hold_d;
   logic                  pend_q, pend_d, ovf_q, ovf_d;
   logic [2:0]            trig_q;
   logic                  trig_edge, tick, last;

   // trig_q[0..1] form the synchroniser, trig_q[2] is the edge-detect history
   assign trig_edge    = trig_q[1] & ~trig_q[2];
   assign tick         = (state_q == CAPTURE) && (div_q == div_l_q);
   assign last         = idx_q == IW'(PACK - 1);
   assign fifo_wr_en   = pend_q & ~fifo_full;
   assign fifo_wr_data = fifo_wr_en ? pword_q : hold_q;
   assign hold_d       = fifo_wr_en ? pword_q : hold_q;
   assign done_pulse   = pend_q && (state_q == CAPTURE) && (lim_q != '0) &&
                         (words_q + CNT_WIDTH'(1) == lim_q);
   assign busy         = (state_q == ARM) || (state_q == CAPTURE);
   assign overflow     = ovf_q;
   assign words_done   = words_q;

   always_comb begin
      state_d = state_q;
      div_l_d = div_l_q;
      lim_d   = lim_q;
      div_d   = div_q;
      idx_d   = idx_q;
      word_d  = word_q;
      pword_d = pword_q;
      pend_d  = 1'b0;
      ovf_d   = ovf_q | (pend_q & fifo_full);
      words_d = (pend_q && !(&words_q)) ? words_q + CNT_WIDTH'(1) : words_q;
      if (tick) begin
         word_d[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
         idx_d   = last ? '0 : idx_q + IW'(1);
         div_d   = '0;
         pend_d  = last & ~done_pulse;
         pword_d = last ? word_d : pword_q;
      end else if (state_q == CAPTURE) begin
         div_d = div_q + DIV_WIDTH'(1);
      end
      case (state_q)
         IDLE: if (enable) begin
            state_d = ARM;
            div_l_d = clk_div;
            lim_d   = word_limit;
            words_d = '0;
            idx_d   = '0;
            ovf_d   = 1'b0;
         end
         ARM: if (!enable) state_d = IDLE;
              else if (trig_edge) begin
                 state_d = CAPTURE;
                 div_d   = '0;
              end
         CAPTURE: if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
         end else if (done_pulse) state_d = DONE;
         DONE: if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         div_l_q <= '0;
         lim_q   <= '0;
         div_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         pword_q <= '0;
         hold_q  <= '0;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
         words_q <= '0;
         trig_q  <= '0;
      end else begin
         state_q <= state_d;
         div_l_q <= div_l_d;
         lim_q   <= lim_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         pword_q <= pword_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         words_q <= words_d;
         trig_q  <= {trig_q[1:0], trig_in};
      end
   end
endmodule
